water_led_ctrl: RTL and testbench



---
 rtl/water_led_ctrl.sv | 151 +++++++++++++++
 tb/tb_water_led_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/water_led_ctrl.sv
// -----------------------------------------------------------------------------
// water_led_ctrl
//
// Running-light sequencer for a bank of board LEDs. A prescaler divides
// sys_clk down to one step every STEP_CYCLES cycles. On each step the pattern
// state (lit position, ping-pong direction, blink phase) advances according
// to mode_i. All outputs are registered and appear one cycle after the
// internal tick. step_o pulses for exactly that cycle.
//
// Ports:
//   sys_clk    - sole clock (PLL output)
//   sys_rst_n  - synchronous, active-low reset
//   en_i       - 1 = run, 0 = pause (prescaler and pattern frozen)
//   clear_i    - synchronous restart to the reset state
//   mode_i     - 00 left, 01 right, 10 ping-pong, 11 all-blink
//   led_o      - LED pin drive, polarity set by LED_ACTIVE_LOW
//   pos_o      - current lit index
//   step_o     - one-cycle strobe when led_o/pos_o show a new step
// -----------------------------------------------------------------------------
module water_led_ctrl #(
    parameter int LED_NUM        = 8,
    parameter int STEP_CYCLES    = 12000000,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               en_i,
    input  logic               clear_i,
    input  logic [1:0]         mode_i,
    output logic [LED_NUM-1:0] led_o,
    output logic [3:0]         pos_o,
    output logic               step_o
);

    localparam int              CNT_W    = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [3:0]      POS_LAST = 4'(LED_NUM - 1);

    localparam logic [1:0] MODE_LEFT  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_PING  = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    localparam logic [LED_NUM-1:0] LIT_ONE  = {{(LED_NUM-1){1'b0}}, 1'b1};
    localparam logic [LED_NUM-1:0] LIT_ALL  = {LED_NUM{1'b1}};
    localparam logic [LED_NUM-1:0] LIT_NONE = {LED_NUM{1'b0}};

    // Pin value that shows only LED0 lit; used on reset and clear.
    localparam logic [LED_NUM-1:0] LED_INIT = LED_ACTIVE_LOW ? ~LIT_ONE : LIT_ONE;

    // Pattern state
    logic [CNT_W-1:0]   cnt,      cnt_nxt;
    logic [3:0]         pos,      pos_nxt;
    logic               dir_up,   dir_up_nxt;
    logic               blink_on, blink_nxt;
    logic               tick;
    logic [LED_NUM-1:0] lit_vec;
    logic [LED_NUM-1:0] led_nxt;

    assign tick  = en_i && (cnt == CNT_LAST);
    assign pos_o = pos;

    // -------------------------------------------------------------------------
    // State register. Reset and clear share the same restart values.
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || clear_i) begin
            cnt      <= '0;
            pos      <= '0;
            dir_up   <= 1'b1;
            blink_on <= 1'b0;
            step_o   <= 1'b0;
            led_o    <= LED_INIT;
        end else begin
            cnt      <= cnt_nxt;
            pos      <= pos_nxt;
            dir_up   <= dir_up_nxt;
            blink_on <= blink_nxt;
            step_o   <= tick;
            // The pin drive only changes on a step, so a mode_i change
            // between ticks never shows up early on the LEDs.
            if (tick) begin
                led_o <= led_nxt;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. With en_i=0, tick is 0 and cnt_nxt=cnt, so the whole
    // block freezes without a separate hold path.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_nxt    = cnt;
        pos_nxt    = pos;
        dir_up_nxt = dir_up;
        blink_nxt  = blink_on;

        if (en_i) begin
            cnt_nxt = tick ? '0 : cnt + 1'b1;
        end

        if (tick) begin
            // Any non-blink step ends the blink phase.
            blink_nxt = 1'b0;
            case (mode_i)
                MODE_LEFT: begin
                    pos_nxt = (pos == POS_LAST) ? 4'd0 : pos + 4'd1;
                end
                MODE_RIGHT: begin
                    pos_nxt = (pos == 4'd0) ? POS_LAST : pos - 4'd1;
                end
                MODE_PING: begin
                    // Bounce turns around on the endpoint step itself so
                    // each endpoint is shown once per pass.
                    if (dir_up) begin
                        if (pos == POS_LAST) begin
                            dir_up_nxt = 1'b0;
                            pos_nxt    = pos - 4'd1;
                        end else begin
                            pos_nxt = pos + 4'd1;
                        end
                    end else begin
                        if (pos == 4'd0) begin
                            dir_up_nxt = 1'b1;
                            pos_nxt    = 4'd1;
                        end else begin
                            pos_nxt = pos - 4'd1;
                        end
                    end
                end
                default: begin
                    blink_nxt = ~blink_on;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode for the step being taken this cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        lit_vec = LIT_NONE;
        if (mode_i == MODE_BLINK) begin
            lit_vec = blink_nxt ? LIT_ALL : LIT_NONE;
        end else begin
            lit_vec = LIT_ONE << pos_nxt;
        end
        led_nxt = LED_ACTIVE_LOW ? ~lit_vec : lit_vec;
    end

endmodule

// File: tb/tb_water_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_water_led_ctrl
//
// Directed bench for water_led_ctrl with LED_NUM=4, STEP_CYCLES=4 and
// active-low LEDs. Inputs change 1 ns after a rising edge; outputs are
// sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_water_led_ctrl;

    localparam int LED_NUM     = 4;
    localparam int STEP_CYCLES = 4;
    localparam int MAX_WAIT    = 20;

    // ---------------- clock / reset ----------------
    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       en_i;
    logic       clear_i;
    logic [1:0] mode_i;
    logic [3:0] led_o;
    logic [3:0] pos_o;
    logic       step_o;

    always #5 sys_clk = ~sys_clk;

    water_led_ctrl #(
        .LED_NUM        (LED_NUM),
        .STEP_CYCLES    (STEP_CYCLES),
        .LED_ACTIVE_LOW (1'b1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en_i      (en_i),
        .clear_i   (clear_i),
        .mode_i    (mode_i),
        .led_o     (led_o),
        .pos_o     (pos_o),
        .step_o    (step_o)
    );

    // ---------------- scoreboard counters ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total_cnt = total_cnt + 1;
        assert (observed === expected) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Active-low pin pattern for a single lit LED.
    function automatic logic [3:0] led_of(input int p);
        case (p)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Wait for the next step_o and check its spacing and the shown state.
    task automatic next_step(input string tag, input int exp_gap,
                             input int exp_pos, input logic [3:0] exp_led);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!step_o && n < MAX_WAIT);
        check({tag, "_gap"}, n, exp_gap);
        check({tag, "_pos"}, pos_o, exp_pos);
        check({tag, "_led"}, led_o, exp_led);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_led"},  led_o,  4'b1110);
        check({tag, "_pos"},  pos_o,  4'd0);
        check({tag, "_step"}, step_o, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    int       exp_left [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    int       exp_right[5]  = '{3, 2, 1, 0, 3};
    int       exp_ping [8]  = '{1, 2, 3, 2, 1, 0, 1, 2};
    logic [3:0] exp_blink[4] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
    logic     saw_step;

    initial begin
        sys_rst_n = 1'b0;
        en_i      = 1'b1;
        clear_i   = 1'b0;
        mode_i    = 2'b00;

        // Reset held for 3 cycles with en_i=1.
        cycles(3);
        check_reset_state("reset");
        sys_rst_n = 1'b1;

        // Mode 00: first step 4 cycles after release, then every 4 cycles.
        for (int i = 0; i < 10; i++) begin
            next_step($sformatf("left%0d", i), STEP_CYCLES, exp_left[i], led_of(exp_left[i]));
        end

        // Mode 11 from pos 2: all-on / all-off, position held.
        mode_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            next_step($sformatf("blink%0d", i), STEP_CYCLES, 2, exp_blink[i]);
        end

        // Back to 00: advance from the held position, blink cleared.
        mode_i = 2'b00;
        next_step("unblink0", STEP_CYCLES, 3, 4'b0111);
        next_step("unblink1", STEP_CYCLES, 0, 4'b1110);

        // Mode 01 from pos 0.
        mode_i = 2'b01;
        for (int i = 0; i < 5; i++) begin
            next_step($sformatf("right%0d", i), STEP_CYCLES, exp_right[i], led_of(exp_right[i]));
        end

        // Clear on a tick cycle (cnt reaches 3 after 3 cycles).
        mode_i = 2'b10;
        cycles(3);
        clear_i = 1'b1;
        cycle();
        check_reset_state("clear");
        clear_i = 1'b0;

        // Mode 10 from the cleared state: dir up.
        for (int i = 0; i < 8; i++) begin
            next_step($sformatf("ping%0d", i), STEP_CYCLES, exp_ping[i], led_of(exp_ping[i]));
        end

        // Pause at cnt=2 for 7 cycles; resume needs 2 more cycles.
        cycles(2);
        en_i     = 1'b0;
        saw_step = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (step_o) saw_step = 1'b1;
        end
        check("pause_no_step", saw_step, 1'b0);
        check("pause_pos", pos_o, 4'd2);
        en_i = 1'b1;
        next_step("resume", 2, 3, 4'b0111);
        next_step("ping_down", STEP_CYCLES, 2, 4'b1011);

        // Mid-run reset while bouncing down; restart goes up again.
        cycle();
        sys_rst_n = 1'b0;
        cycles(2);
        check_reset_state("midreset");
        sys_rst_n = 1'b1;
        next_step("after_rst0", STEP_CYCLES, 1, 4'b1101);
        next_step("after_rst1", STEP_CYCLES, 2, 4'b1011);
        next_step("after_rst2", STEP_CYCLES, 3, 4'b0111);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
